// File: rtl/scroll_display_buffer.sv
// Character-cell display buffer with hardware scroll (rotating top row) and a
// background clear engine that owns the write port while busy.
module scroll_display_buffer #(
   parameter int unsigned    ROWS      = 30,
   parameter int unsigned    COLS      = 80,
   parameter int unsigned    DW        = 33,
   parameter logic [DW-1:0]  CLEAR_VAL = 33'h0F0000F20,
   localparam int unsigned   RW        = $clog2(ROWS),
   localparam int unsigned   CW        = $clog2(COLS)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          we,
   input  logic [RW-1:0] wr,
   input  logic [CW-1:0] wc,
   input  logic [DW-1:0] wd,
   input  logic [RW-1:0] rr,
   input  logic [CW-1:0] rc,
   output logic [DW-1:0] rd,
   input  logic          scroll,
   input  logic          clr,
   output logic          busy,
   output logic [RW-1:0] top
);

   localparam int unsigned   DEPTH        = ROWS * COLS;
   localparam int unsigned   AW           = $clog2(DEPTH);
   localparam logic [RW:0]   ROWS_W       = (RW+1)'(ROWS);
   localparam logic [CW:0]   COLS_W       = (CW+1)'(COLS);
   localparam logic [RW-1:0] TOP_LAST     = RW'(ROWS - 1);
   localparam logic [AW-1:0] CNT_LAST_ALL = AW'(DEPTH - 1);
   localparam logic [AW-1:0] CNT_LAST_ROW = AW'(COLS - 1);

   typedef enum logic [1:0] {IDLE, CLR_ALL, CLR_ROW} state_t;

   // One extra bit keeps lr + t from overflowing before the modulo fold.
   function automatic logic [RW-1:0] map_row(input logic [RW-1:0] lr, input logic [RW-1:0] t);
      logic [RW:0] s;
      s = {1'b0, lr} + {1'b0, t};
      if (s >= ROWS_W) s = s - ROWS_W;
      return s[RW-1:0];
   endfunction

   function automatic logic [AW-1:0] cell_addr(input logic [RW-1:0] pr, input logic [AW-1:0] col);
      return AW'(pr) * AW'(COLS) + col;
   endfunction

   state_t        r_state;
   logic [AW-1:0] r_cnt;
   logic [RW-1:0] r_top;
   logic [RW-1:0] r_row;
   logic [DW-1:0] r_rd;
   logic [DW-1:0] r_mem [DEPTH];

   logic          w_wr_ok;
   logic          w_rd_ok;
   logic [AW-1:0] w_waddr;
   logic [AW-1:0] w_raddr;
   logic          w_mem_we;
   logic [AW-1:0] w_mem_addr;
   logic [DW-1:0] w_mem_wd;

   assign w_wr_ok = ({1'b0, wr} < ROWS_W) && ({1'b0, wc} < COLS_W);
   assign w_rd_ok = ({1'b0, rr} < ROWS_W) && ({1'b0, rc} < COLS_W);
   assign w_waddr = cell_addr(map_row(wr, r_top), AW'(wc));
   assign w_raddr = cell_addr(map_row(rr, r_top), AW'(rc));

   always_comb begin
      w_mem_we   = 1'b0;
      w_mem_addr = w_waddr;
      w_mem_wd   = wd;
      case (r_state)
         IDLE: begin
            w_mem_we = we && w_wr_ok;
         end
         CLR_ALL: begin
            w_mem_we   = 1'b1;
            w_mem_addr = r_cnt;
            w_mem_wd   = CLEAR_VAL;
         end
         CLR_ROW: begin
            w_mem_we   = 1'b1;
            w_mem_addr = cell_addr(r_row, r_cnt);
            w_mem_wd   = CLEAR_VAL;
         end
         default: begin
            w_mem_we = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_mem_we) r_mem[w_mem_addr] <= w_mem_wd;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= CLR_ALL;
         r_cnt   <= '0;
         r_top   <= '0;
         r_row   <= '0;
         r_rd    <= '0;
      end else begin
         r_rd <= w_rd_ok ? r_mem[w_raddr] : CLEAR_VAL;
         case (r_state)
            IDLE: begin
               if (clr) begin
                  r_state <= CLR_ALL;
                  r_cnt   <= '0;
                  r_top   <= '0;
               end else if (scroll) begin
                  // The old top row becomes the new bottom row and is blanked.
                  r_state <= CLR_ROW;
                  r_cnt   <= '0;
                  r_row   <= r_top;
                  r_top   <= (r_top == TOP_LAST) ? '0 : r_top + RW'(1);
               end
            end
            CLR_ALL: begin
               if (r_cnt == CNT_LAST_ALL) r_state <= IDLE;
               else                       r_cnt   <= r_cnt + AW'(1);
            end
            CLR_ROW: begin
               if (clr) begin
                  r_state <= CLR_ALL;
                  r_cnt   <= '0;
                  r_top   <= '0;
               end else if (r_cnt == CNT_LAST_ROW) begin
                  r_state <= IDLE;
               end else begin
                  r_cnt <= r_cnt + AW'(1);
               end
            end
            default: begin
               r_state <= CLR_ALL;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   assign busy = (r_state != IDLE);
   assign top  = r_top;
   assign rd   = r_rd;

endmodule

// File: tb/tb_scroll_display_buffer.sv
// Directed bench for scroll_display_buffer: vector table for plain read/write,
// hand sequences for clear, scroll, abort and mid-operation reset.
module tb_scroll_display_buffer;

   localparam logic [32:0] CLR = 33'h0F0000F20;

   typedef struct {
      logic        we;
      logic [4:0]  wr;
      logic [6:0]  wc;
      logic [32:0] wd;
      logic [4:0]  rr;
      logic [6:0]  rc;
      logic [32:0] exp_rd;
   } vec_t;

   logic        clk     = 1'b0;
   logic        reset_n = 1'b1;
   logic        we      = 1'b0;
   logic [4:0]  wr      = '0;
   logic [6:0]  wc      = '0;
   logic [32:0] wd      = '0;
   logic [4:0]  rr      = '0;
   logic [6:0]  rc      = '0;
   logic        scroll  = 1'b0;
   logic        clr     = 1'b0;
   logic [32:0] rd;
   logic        busy;
   logic [4:0]  top;

   int checks = 0;
   int errors = 0;
   int n;
   int exp_top;
   vec_t vt [9];

   scroll_display_buffer dut (
      .clk     (clk),
      .reset_n (reset_n),
      .we      (we),
      .wr      (wr),
      .wc      (wc),
      .wd      (wd),
      .rr      (rr),
      .rc      (rc),
      .rd      (rd),
      .scroll  (scroll),
      .clr     (clr),
      .busy    (busy),
      .top     (top)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_idle(output int cnt);
      cnt = 0;
      while (busy === 1'b1 && cnt < 3000) begin
         tick();
         cnt++;
      end
   endtask

   task automatic wr_cell(input logic [4:0] r, input logic [6:0] c, input logic [32:0] d);
      we = 1'b1; wr = r; wc = c; wd = d;
      tick();
      we = 1'b0;
   endtask

   task automatic rd_chk(input string nm, input logic [4:0] r, input logic [6:0] c, input logic [32:0] e);
      rr = r; rc = c;
      tick();
      chk(nm, 64'(rd), 64'(e));
   endtask

   initial begin
      vt[0] = '{1'b1, 5'd2,  7'd5,  33'h1ABC12341, 5'd2,  7'd5,  CLR};
      vt[1] = '{1'b0, 5'd0,  7'd0,  33'h0,         5'd2,  7'd5,  33'h1ABC12341};
      vt[2] = '{1'b1, 5'd30, 7'd0,  33'h123456789, 5'd29, 7'd79, CLR};
      vt[3] = '{1'b1, 5'd0,  7'd80, 33'h1DEADBEEF, 5'd30, 7'd0,  CLR};
      vt[4] = '{1'b0, 5'd0,  7'd0,  33'h0,         5'd0,  7'd80, CLR};
      vt[5] = '{1'b0, 5'd0,  7'd0,  33'h0,         5'd0,  7'd0,  CLR};
      vt[6] = '{1'b0, 5'd0,  7'd0,  33'h0,         5'd1,  7'd0,  CLR};
      vt[7] = '{1'b1, 5'd29, 7'd79, 33'h0AAAA5555, 5'd2,  7'd5,  33'h1ABC12341};
      vt[8] = '{1'b0, 5'd0,  7'd0,  33'h0,         5'd29, 7'd79, 33'h0AAAA5555};

      #2 reset_n = 1'b0;
      tick();
      tick();
      chk("rst_busy", 64'(busy), 64'd1);
      chk("rst_top",  64'(top),  64'd0);
      chk("rst_rd",   64'(rd),   64'd0);
      reset_n = 1'b1;
      wait_idle(n);
      chk("rst_clear_cycles", 64'(n), 64'd2400);
      rd_chk("rst_cell_29_79", 5'd29, 7'd79, CLR);

      for (int i = 0; i < 9; i++) begin
         we = vt[i].we; wr = vt[i].wr; wc = vt[i].wc; wd = vt[i].wd;
         rr = vt[i].rr; rc = vt[i].rc;
         tick();
         we = 1'b0;
         chk($sformatf("vec%0d_rd", i),   64'(rd),   64'(vt[i].exp_rd));
         chk($sformatf("vec%0d_busy", i), 64'(busy), 64'd0);
      end

      // Scroll with a same-cycle write (pre-scroll mapping), then writes and
      // scroll pulses held throughout the row clear must have no effect.
      wr_cell(5'd1, 7'd0, 33'h155556666);
      wr_cell(5'd0, 7'd7, 33'h100000007);
      we = 1'b1; wr = 5'd3; wc = 7'd3; wd = 33'h012345678; scroll = 1'b1;
      tick();
      chk("scroll_top",  64'(top),  64'd1);
      chk("scroll_busy", 64'(busy), 64'd1);
      wr = 5'd1; wc = 7'd5; wd = 33'h00BAD0BAD;
      wait_idle(n);
      we = 1'b0; scroll = 1'b0;
      chk("scroll_row_cycles", 64'(n),   64'd80);
      chk("scroll_top_held",   64'(top), 64'd1);
      rd_chk("scroll_0_0",   5'd0,  7'd0,  33'h155556666);
      rd_chk("scroll_29_0",  5'd29, 7'd0,  CLR);
      rd_chk("scroll_29_7",  5'd29, 7'd7,  CLR);
      rd_chk("scroll_28_79", 5'd28, 7'd79, 33'h0AAAA5555);
      rd_chk("scroll_2_3",   5'd2,  7'd3,  33'h012345678);
      rd_chk("busy_wr_drop", 5'd1,  7'd5,  33'h1ABC12341);

      // 28 scrolls reach top=29, the next wraps to 0, 29 more return to 29.
      exp_top = 1;
      for (int k = 0; k < 58; k++) begin
         scroll = 1'b1;
         tick();
         scroll = 1'b0;
         exp_top = (exp_top == 29) ? 0 : exp_top + 1;
         chk($sformatf("scroll%0d_top", k), 64'(top), 64'(exp_top));
         wait_idle(n);
         chk($sformatf("scroll%0d_cycles", k), 64'(n), 64'd80);
      end

      // clr wins over scroll; clr/scroll held during CLR_ALL are ignored.
      wr_cell(5'd5, 7'd5, 33'h1F00F00AA);
      clr = 1'b1; scroll = 1'b1;
      tick();
      chk("clrscr_top",  64'(top),  64'd0);
      chk("clrscr_busy", 64'(busy), 64'd1);
      wait_idle(n);
      clr = 1'b0; scroll = 1'b0;
      chk("clrscr_cycles", 64'(n), 64'd2400);
      chk("clrscr_top_after", 64'(top), 64'd0);
      rd_chk("clrscr_5_5", 5'd5, 7'd5, CLR);

      // clr at the tenth cycle of a row clear restarts a full clear.
      wr_cell(5'd3, 7'd3, 33'h0CAFE0001);
      scroll = 1'b1;
      tick();
      scroll = 1'b0;
      chk("abort_scroll_top", 64'(top), 64'd1);
      for (int k = 0; k < 9; k++) tick();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("abort_top",  64'(top),  64'd0);
      chk("abort_busy", 64'(busy), 64'd1);
      wait_idle(n);
      chk("abort_cycles", 64'(n), 64'd2400);
      rd_chk("abort_3_3", 5'd3, 7'd3, CLR);

      // Asynchronous reset in the middle of a row clear.
      wr_cell(5'd4, 7'd4, 33'h0DEAD0004);
      scroll = 1'b1;
      tick();
      scroll = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      #2 reset_n = 1'b0;
      #1;
      chk("midrst_busy", 64'(busy), 64'd1);
      chk("midrst_top",  64'(top),  64'd0);
      chk("midrst_rd",   64'(rd),   64'd0);
      tick();
      tick();
      reset_n = 1'b1;
      wait_idle(n);
      chk("midrst_cycles", 64'(n), 64'd2400);
      rd_chk("midrst_4_4", 5'd4, 7'd4, CLR);
      chk("midrst_top_after", 64'(top), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
